spi_transaction_fsm: RTL

Transaction controller for the SPI slave datapath. It sits directly downstream of the serial shift register and consumes its parallel output. It counts SCLK rising-edge pulses, decodes the command byte (address plus read/write bit), and drives the shift register's `parallelLoad` for reads. It also issues a single-cycle write strobe to the data memory for writes.

---
 rtl/spi_transaction_fsm.sv | 99 +++++++++
 1 files changed

// File: rtl/spi_transaction_fsm.sv
// SPI slave transaction controller: counts SCLK pulses, decodes the {address, rw} command
// byte and sequences either the shift-register load (read) or the memory write strobe (write).
module spi_transaction_fsm #(
  parameter int width     = 8,
  parameter int addrWidth = 7
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 csN,
  input  logic                 peripheralClkEdge,
  input  logic [width-1:0]     shiftRegOut,
  output logic [addrWidth-1:0] address,
  output logic                 parallelLoad,
  output logic                 dataMemWriteEnable,
  output logic                 misoBufferEnable,
  output logic                 busy
);

  // state        | meaning
  // IDLE         | chip deselected, all outputs low
  // GET_CMD      | shifting in the command byte
  // LATCH_CMD    | one cycle: capture address, pick read or write path
  // READ_LOAD    | parallelLoad held until the next SCLK pulse performs the load
  // READ_SHIFT   | shifting the read word out on MISO
  // WRITE_SHIFT  | shifting in the write data word
  // WRITE_COMMIT | one-cycle memory write strobe
  // DONE         | word finished, extra pulses ignored until csN rises

  localparam int countWidth = $clog2(width + 1);
  localparam logic [countWidth-1:0] lastCount = countWidth'(width - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    LATCH_CMD,
    READ_LOAD,
    READ_SHIFT,
    WRITE_SHIFT,
    WRITE_COMMIT,
    DONE
  } txnStateT;

  txnStateT              state;
  txnStateT              nextState;
  logic [countWidth-1:0] bitCount;
  logic                  lastPulse;

  assign lastPulse = peripheralClkEdge && (bitCount == lastCount);

  always_comb begin
    nextState = state;
    if (state != IDLE && csN) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:         if (!csN) nextState = GET_CMD;
        GET_CMD:      if (lastPulse) nextState = LATCH_CMD;
        LATCH_CMD:    nextState = shiftRegOut[0] ? READ_LOAD : WRITE_SHIFT;
        READ_LOAD:    if (peripheralClkEdge) nextState = READ_SHIFT;
        READ_SHIFT:   if (lastPulse) nextState = DONE;
        WRITE_SHIFT:  if (lastPulse) nextState = WRITE_COMMIT;
        WRITE_COMMIT: nextState = DONE;
        DONE:         nextState = DONE;
        default:      nextState = IDLE;
      endcase
    end
  end

  // The load pulse in READ_LOAD also shifts out the first data bit, so it is counted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state              <= IDLE;
      bitCount           <= '0;
      address            <= '0;
      parallelLoad       <= 1'b0;
      dataMemWriteEnable <= 1'b0;
      misoBufferEnable   <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state <= nextState;

      case (state)
        GET_CMD, READ_LOAD, READ_SHIFT, WRITE_SHIFT:
          if (peripheralClkEdge) bitCount <= bitCount + countWidth'(1);
        default:
          bitCount <= '0;
      endcase
      if (csN) bitCount <= '0;

      if (state == LATCH_CMD && !csN) address <= shiftRegOut[width-1:1];

      parallelLoad       <= (nextState == READ_LOAD);
      misoBufferEnable   <= (nextState == READ_LOAD) || (nextState == READ_SHIFT);
      dataMemWriteEnable <= (nextState == WRITE_COMMIT);
      busy               <= (nextState != IDLE);
    end
  end

endmodule
